voice_allocator: RTL and testbench

- Schedules note events onto the voice table: assigns each note-on to a voice slot and locates the slot for each note-off.
- Issues single-cycle write commands on the control port of the voice RAM. Never writes the slot the sample engine is currently servicing.
- Keeps a shadow status table in flops (active, releasing, note, channel, age stamp per voice), so voices are found without reading the RAM.
- Sits between the MIDI event FIFO (upstream) and the voice RAM / sample engine (downstream).

---
 rtl/voice_allocator.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Takes note events from the MIDI event FIFO and places them in the voice table.
// A note-on gets a voice slot. A note-off finds the voice that is playing that
// note. Each event then becomes a single-cycle write on the voice RAM control
// port.
//
// A shadow status table is kept in flops, one entry per voice:
//     active, releasing, note, channel, age stamp.
// Because of this table, slot selection never has to read the voice RAM.
// A write is held back while the sample engine is addressing the target slot.
//
// Ports
//     clk32, rst        system clock, synchronous active-high reset
//     ev_*              event handshake and payload (valid/ready)
//     rel_done_*        sample engine reports that a voice finished its release
//     sample_en/addr    voice currently serviced by the sample engine
//     wr_*              registered write command to the voice RAM
//     active_count      registered population count of active voices
//     stolen            pulse, with wr_en, when a note-on took an occupied voice
//     dropped           pulse when a note-off matched no voice
// -----------------------------------------------------------------------------
module voice_allocator #(
    parameter int NUM_VOICES = 32,
    parameter int ADDR_W     = 5,
    parameter int STAMP_W    = 8
) (
    input  logic              clk32,
    input  logic              rst,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic              ev_on,
    input  logic [6:0]        ev_note,
    input  logic [6:0]        ev_velocity,
    input  logic [3:0]        ev_channel,
    input  logic              rel_done_valid,
    input  logic [ADDR_W-1:0] rel_done_voice,
    input  logic              sample_en,
    input  logic [ADDR_W-1:0] sample_addr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_note,
    output logic [3:0]        wr_channel,
    output logic [6:0]        wr_velocity,
    output logic              wr_press,
    output logic              wr_release,
    output logic [ADDR_W:0]   active_count,
    output logic              stolen,
    output logic              dropped
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN      = 2'd1,
        COMMIT    = 2'd2,
        WAIT_PORT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_VOICE = ADDR_W'(NUM_VOICES - 1);

    // Count the set bits of the active vector.
    function automatic logic [ADDR_W:0] popcount(input logic [NUM_VOICES-1:0] bits);
        logic [ADDR_W:0] sum;
        sum = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < NUM_VOICES; i++) begin
            sum = sum + {{ADDR_W{1'b0}}, bits[i]};
        end
        return sum;
    endfunction

    // FSM state
    state_t state_r;
    state_t state_s;

    // Latched event
    logic              ev_on_r;
    logic [6:0]        ev_note_r;
    logic [6:0]        ev_vel_r;
    logic [3:0]        ev_ch_r;
    logic [ADDR_W-1:0] scan_idx_r;

    // Shadow status table
    logic [NUM_VOICES-1:0] active_r;
    logic [NUM_VOICES-1:0] releasing_r;
    logic [6:0]            note_tab_r  [NUM_VOICES];
    logic [3:0]            chan_tab_r  [NUM_VOICES];
    logic [STAMP_W-1:0]    stamp_tab_r [NUM_VOICES];
    logic [STAMP_W-1:0]    gstamp_r;

    // Scan candidates. Each one is the best voice found so far in its category.
    logic               retrig_hit_r;
    logic [ADDR_W-1:0]  retrig_idx_r;
    logic               free_hit_r;
    logic [ADDR_W-1:0]  free_idx_r;
    logic               rel_hit_r;
    logic [ADDR_W-1:0]  rel_idx_r;
    logic [STAMP_W-1:0] rel_age_r;
    logic               act_hit_r;
    logic [ADDR_W-1:0]  act_idx_r;
    logic [STAMP_W-1:0] act_age_r;
    logic               off_hit_r;
    logic [ADDR_W-1:0]  off_idx_r;

    // Registered outputs
    logic              ev_ready_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [6:0]        wr_note_r;
    logic [3:0]        wr_ch_r;
    logic [6:0]        wr_vel_r;
    logic              wr_press_r;
    logic              wr_release_r;
    logic [ADDR_W:0]   active_count_r;
    logic              stolen_r;
    logic              dropped_r;

    // Combinational helpers
    logic               accept_s;
    logic               do_write_s;
    logic               do_drop_s;
    logic [ADDR_W-1:0]  tgt_s;
    logic               steal_s;
    logic               tgt_ok_s;
    logic               port_busy_s;
    logic               cur_active_s;
    logic               cur_rel_s;
    logic               cur_match_s;
    logic [STAMP_W-1:0] cur_age_s;

    // Select the target voice from the scan candidates, in priority order.
    always_comb begin
        tgt_s    = {ADDR_W{1'b0}};
        steal_s  = 1'b0;
        tgt_ok_s = 1'b0;
        if (ev_on_r) begin
            tgt_ok_s = 1'b1;
            if (retrig_hit_r) begin
                tgt_s = retrig_idx_r;
            end else if (free_hit_r) begin
                tgt_s = free_idx_r;
            end else if (rel_hit_r) begin
                tgt_s   = rel_idx_r;
                steal_s = 1'b1;
            end else begin
                tgt_s   = act_idx_r;
                steal_s = 1'b1;
            end
        end else begin
            tgt_s = off_idx_r;
            // The voice may have been freed after the scan found it.
            tgt_ok_s = off_hit_r && active_r[off_idx_r] && !releasing_r[off_idx_r];
        end
    end

    assign port_busy_s = sample_en && (sample_addr == tgt_s);

    // Read the shadow entry of the voice being scanned in this cycle.
    always_comb begin
        cur_active_s = active_r[scan_idx_r];
        cur_rel_s    = releasing_r[scan_idx_r];
        cur_match_s  = (note_tab_r[scan_idx_r] == ev_note_r) &&
                       (chan_tab_r[scan_idx_r] == ev_ch_r);
        // The modular difference keeps ages correct across stamp wrap.
        cur_age_s    = gstamp_r - stamp_tab_r[scan_idx_r];
    end

    // Next-state logic and command decode.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        do_write_s = 1'b0;
        do_drop_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (ev_valid) begin
                    accept_s = 1'b1;
                    state_s  = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (scan_idx_r == LAST_VOICE) begin
                    state_s = COMMIT;
                end else begin
                    state_s = SCAN;
                end
            end
            COMMIT, WAIT_PORT: begin
                if (!tgt_ok_s) begin
                    do_drop_s = 1'b1;
                    state_s   = IDLE;
                end else if (port_busy_s) begin
                    state_s = WAIT_PORT;
                end else begin
                    do_write_s = 1'b1;
                    state_s    = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk32) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the event and track the scan candidates.
    always_ff @(posedge clk32) begin
        if (rst) begin
            ev_on_r      <= 1'b0;
            ev_note_r    <= 7'd0;
            ev_vel_r     <= 7'd0;
            ev_ch_r      <= 4'd0;
            scan_idx_r   <= {ADDR_W{1'b0}};
            retrig_hit_r <= 1'b0;
            retrig_idx_r <= {ADDR_W{1'b0}};
            free_hit_r   <= 1'b0;
            free_idx_r   <= {ADDR_W{1'b0}};
            rel_hit_r    <= 1'b0;
            rel_idx_r    <= {ADDR_W{1'b0}};
            rel_age_r    <= {STAMP_W{1'b0}};
            act_hit_r    <= 1'b0;
            act_idx_r    <= {ADDR_W{1'b0}};
            act_age_r    <= {STAMP_W{1'b0}};
            off_hit_r    <= 1'b0;
            off_idx_r    <= {ADDR_W{1'b0}};
        end else if (accept_s) begin
            ev_on_r      <= ev_on;
            ev_note_r    <= ev_note;
            ev_vel_r     <= ev_velocity;
            ev_ch_r      <= ev_channel;
            scan_idx_r   <= {ADDR_W{1'b0}};
            retrig_hit_r <= 1'b0;
            free_hit_r   <= 1'b0;
            rel_hit_r    <= 1'b0;
            act_hit_r    <= 1'b0;
            off_hit_r    <= 1'b0;
        end else if (state_r == SCAN) begin
            scan_idx_r <= scan_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            // Ascending scan: the first hit is the lowest index. Strict '>' on
            // age keeps the lower index on a tie.
            if (cur_active_s && cur_match_s && !retrig_hit_r) begin
                retrig_hit_r <= 1'b1;
                retrig_idx_r <= scan_idx_r;
            end
            if (!cur_active_s && !free_hit_r) begin
                free_hit_r <= 1'b1;
                free_idx_r <= scan_idx_r;
            end
            if (cur_active_s && cur_rel_s && (!rel_hit_r || (cur_age_s > rel_age_r))) begin
                rel_hit_r <= 1'b1;
                rel_idx_r <= scan_idx_r;
                rel_age_r <= cur_age_s;
            end
            if (cur_active_s && (!act_hit_r || (cur_age_s > act_age_r))) begin
                act_hit_r <= 1'b1;
                act_idx_r <= scan_idx_r;
                act_age_r <= cur_age_s;
            end
            if (cur_active_s && !cur_rel_s && cur_match_s && !off_hit_r) begin
                off_hit_r <= 1'b1;
                off_idx_r <= scan_idx_r;
            end
        end
    end

    // Shadow table update from release completions and from committed writes.
    always_ff @(posedge clk32) begin
        if (rst) begin
            active_r    <= {NUM_VOICES{1'b0}};
            releasing_r <= {NUM_VOICES{1'b0}};
            gstamp_r    <= {STAMP_W{1'b0}};
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_tab_r[i]  <= 7'd0;
                chan_tab_r[i]  <= 4'd0;
                stamp_tab_r[i] <= {STAMP_W{1'b0}};
            end
        end else begin
            if (rel_done_valid && releasing_r[rel_done_voice]) begin
                active_r[rel_done_voice]    <= 1'b0;
                releasing_r[rel_done_voice] <= 1'b0;
            end
            // Placed after the release clear, so a commit to the same voice wins.
            if (do_write_s) begin
                if (ev_on_r) begin
                    active_r[tgt_s]    <= 1'b1;
                    releasing_r[tgt_s] <= 1'b0;
                    note_tab_r[tgt_s]  <= ev_note_r;
                    chan_tab_r[tgt_s]  <= ev_ch_r;
                    stamp_tab_r[tgt_s] <= gstamp_r;
                    gstamp_r           <= gstamp_r + {{(STAMP_W-1){1'b0}}, 1'b1};
                end else begin
                    active_r[tgt_s]    <= 1'b1;
                    releasing_r[tgt_s] <= 1'b1;
                end
            end
        end
    end

    // Registered outputs. Write data holds its value between strobes.
    always_ff @(posedge clk32) begin
        if (rst) begin
            ev_ready_r     <= 1'b1;
            wr_en_r        <= 1'b0;
            wr_addr_r      <= {ADDR_W{1'b0}};
            wr_note_r      <= 7'd0;
            wr_ch_r        <= 4'd0;
            wr_vel_r       <= 7'd0;
            wr_press_r     <= 1'b0;
            wr_release_r   <= 1'b0;
            active_count_r <= {(ADDR_W+1){1'b0}};
            stolen_r       <= 1'b0;
            dropped_r      <= 1'b0;
        end else begin
            ev_ready_r     <= (state_s == IDLE);
            wr_en_r        <= do_write_s;
            stolen_r       <= do_write_s && steal_s;
            dropped_r      <= do_drop_s;
            active_count_r <= popcount(active_r);
            if (do_write_s) begin
                wr_addr_r    <= tgt_s;
                wr_note_r    <= ev_on_r ? ev_note_r : note_tab_r[tgt_s];
                wr_ch_r      <= ev_on_r ? ev_ch_r : chan_tab_r[tgt_s];
                wr_vel_r     <= ev_vel_r;
                wr_press_r   <= ev_on_r;
                wr_release_r <= !ev_on_r;
            end
        end
    end

    assign ev_ready     = ev_ready_r;
    assign wr_en        = wr_en_r;
    assign wr_addr      = wr_addr_r;
    assign wr_note      = wr_note_r;
    assign wr_channel   = wr_ch_r;
    assign wr_velocity  = wr_vel_r;
    assign wr_press     = wr_press_r;
    assign wr_release   = wr_release_r;
    assign active_count = active_count_r;
    assign stolen       = stolen_r;
    assign dropped      = dropped_r;

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//
// Directed, self-checking bench for voice_allocator.
// Each event's expected write or drop is pushed to a queue when the event is
// driven. It is popped and compared when the DUT responds.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int NV = 32;
    localparam int AW = 5;

    logic          clk32 = 1'b0;
    logic          rst = 1'b1;
    logic          ev_valid = 1'b0;
    logic          ev_ready;
    logic          ev_on = 1'b0;
    logic [6:0]    ev_note = 7'd0;
    logic [6:0]    ev_velocity = 7'd0;
    logic [3:0]    ev_channel = 4'd0;
    logic          rel_done_valid = 1'b0;
    logic [AW-1:0] rel_done_voice = 5'd0;
    logic          sample_en = 1'b0;
    logic [AW-1:0] sample_addr = 5'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_note;
    logic [3:0]    wr_channel;
    logic [6:0]    wr_velocity;
    logic          wr_press;
    logic          wr_release;
    logic [AW:0]   active_count;
    logic          stolen;
    logic          dropped;

    typedef struct {
        bit         drop;
        logic [4:0] addr;
        logic [6:0] note;
        logic [3:0] ch;
        logic [6:0] vel;
        bit         press;
        bit         rel;
        bit         stl;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    voice_allocator #(.NUM_VOICES(NV), .ADDR_W(AW), .STAMP_W(8)) dut (
        .clk32(clk32), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
        .ev_note(ev_note), .ev_velocity(ev_velocity), .ev_channel(ev_channel),
        .rel_done_valid(rel_done_valid), .rel_done_voice(rel_done_voice),
        .sample_en(sample_en), .sample_addr(sample_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
        .wr_channel(wr_channel), .wr_velocity(wr_velocity),
        .wr_press(wr_press), .wr_release(wr_release),
        .active_count(active_count), .stolen(stolen), .dropped(dropped)
    );

    always #5 clk32 = ~clk32;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Builds an expected write; drop=1 means "dropped pulse, no write".
    function automatic exp_t mk(input bit drop, input int addr, input int note, input int ch,
                                input int vel, input bit press, input bit rel, input bit stl,
                                input int lat);
        exp_t e;
        e.drop  = drop;
        e.addr  = addr[4:0];
        e.note  = note[6:0];
        e.ch    = ch[3:0];
        e.vel   = vel[6:0];
        e.press = press;
        e.rel   = rel;
        e.stl   = stl;
        e.lat   = lat;
        return e;
    endfunction

    // Drive one event. Optionally block the target port for 'hold' cycles at
    // commit, then compare the response against the scoreboard head.
    task automatic send(input bit on, input int note, input int vel, input int ch,
                        input int hold, input exp_t e);
        int   g;
        int   k;
        bit   seen;
        exp_t x;
        exp_q.push_back(e);
        g = 0;
        while (!ev_ready && g < 100) begin
            @(posedge clk32);
            #1;
            g++;
        end
        check("ready_before_event", 32'(ev_ready), 32'd1);
        ev_on       = on;
        ev_note     = note[6:0];
        ev_velocity = vel[6:0];
        ev_channel  = ch[3:0];
        ev_valid    = 1'b1;
        @(posedge clk32);
        #1;
        ev_valid = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            @(posedge clk32);
            k++;
            #1;
            if (wr_en || dropped) begin
                seen = 1'b1;
            end
            if (hold > 0 && k == NV) begin
                sample_en   = 1'b1;
                sample_addr = e.addr;
            end
            if (hold > 0 && k == NV + hold) begin
                sample_en = 1'b0;
            end
        end
        sample_en = 1'b0;
        x = exp_q.pop_front();
        check("latency", 32'(k), 32'(x.lat));
        check("wr_en", 32'(wr_en), 32'(!x.drop));
        check("dropped", 32'(dropped), 32'(x.drop));
        if (!x.drop) begin
            check("wr_addr", 32'(wr_addr), 32'(x.addr));
            check("wr_note", 32'(wr_note), 32'(x.note));
            check("wr_channel", 32'(wr_channel), 32'(x.ch));
            check("wr_velocity", 32'(wr_velocity), 32'(x.vel));
            check("wr_press", 32'(wr_press), 32'(x.press));
            check("wr_release", 32'(wr_release), 32'(x.rel));
            check("stolen", 32'(stolen), 32'(x.stl));
        end
        @(posedge clk32);
        #1;
        check("strobe_one_cycle", 32'({wr_en, stolen, dropped}), 32'd0);
    endtask

    initial begin
        int nwr;

        // Reset
        repeat (2) @(posedge clk32);
        #1;
        rst = 1'b0;
        check("rst_ev_ready", 32'(ev_ready), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_active_count", 32'(active_count), 32'd0);
        check("rst_pulses", 32'({stolen, dropped}), 32'd0);

        // First note-on goes to voice 0, NV+1 cycles after accept
        send(1'b1, 60, 100, 0, 0, mk(1'b0, 0, 60, 0, 100, 1'b1, 1'b0, 1'b0, NV + 1));
        check("count_after_first_on", 32'(active_count), 32'd1);

        // Retrigger of the same note and channel
        send(1'b1, 60, 90, 0, 0, mk(1'b0, 0, 60, 0, 90, 1'b1, 1'b0, 1'b0, NV + 1));
        check("count_after_retrig", 32'(active_count), 32'd1);

        // Note-off of note 60
        send(1'b0, 60, 50, 0, 0, mk(1'b0, 0, 60, 0, 50, 1'b0, 1'b1, 1'b0, NV + 1));
        check("count_while_releasing", 32'(active_count), 32'd1);

        // Release completes on voice 0
        rel_done_valid = 1'b1;
        rel_done_voice = 5'd0;
        @(posedge clk32);
        #1;
        rel_done_valid = 1'b0;
        @(posedge clk32);
        #1;
        check("count_after_rel_done", 32'(active_count), 32'd0);

        // Note-off with no matching voice
        send(1'b0, 61, 10, 0, 0, mk(1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, NV + 1));

        // Fill every voice with notes 0..31
        for (int i = 0; i < NV; i++) begin
            send(1'b1, i, 64, 0, 0, mk(1'b0, i, i, 0, 64, 1'b1, 1'b0, 1'b0, NV + 1));
        end
        check("count_full", 32'(active_count), 32'(NV));

        // rel_done on a voice that is not releasing is ignored
        rel_done_valid = 1'b1;
        rel_done_voice = 5'd3;
        @(posedge clk32);
        #1;
        rel_done_valid = 1'b0;
        @(posedge clk32);
        #1;
        check("count_rel_done_ignored", 32'(active_count), 32'(NV));

        // Release note 5; the next note-on steals the releasing voice
        send(1'b0, 5, 20, 0, 0, mk(1'b0, 5, 5, 0, 20, 1'b0, 1'b1, 1'b0, NV + 1));
        send(1'b1, 40, 70, 0, 0, mk(1'b0, 5, 40, 0, 70, 1'b1, 1'b0, 1'b1, NV + 1));

        // No releasing voice left: the oldest active voice (voice 0) is stolen
        send(1'b1, 41, 71, 0, 0, mk(1'b0, 0, 41, 0, 71, 1'b1, 1'b0, 1'b1, NV + 1));

        // Next-oldest is voice 1. The port stays busy for 4 cycles at commit.
        send(1'b1, 42, 72, 0, 4, mk(1'b0, 1, 42, 0, 72, 1'b1, 1'b0, 1'b1, NV + 5));
        check("count_after_steals", 32'(active_count), 32'(NV));

        // Note 40 sounds on channel 0 only, so a channel-1 note-off is dropped
        send(1'b0, 40, 30, 1, 0, mk(1'b1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, NV + 1));

        // Reset in the middle of a scan aborts the event
        ev_on       = 1'b1;
        ev_note     = 7'd90;
        ev_velocity = 7'd90;
        ev_channel  = 4'd2;
        ev_valid    = 1'b1;
        @(posedge clk32);
        #1;
        ev_valid = 1'b0;
        repeat (10) @(posedge clk32);
        #1;
        rst = 1'b1;
        @(posedge clk32);
        #1;
        rst = 1'b0;
        check("midscan_rst_ev_ready", 32'(ev_ready), 32'd1);
        check("midscan_rst_count", 32'(active_count), 32'd0);
        nwr = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk32);
            #1;
            if (wr_en) begin
                nwr++;
            end
        end
        check("midscan_rst_no_write", 32'(nwr), 32'd0);

        // After reset, allocation starts again from voice 0
        send(1'b1, 60, 100, 0, 0, mk(1'b0, 0, 60, 0, 100, 1'b1, 1'b0, 1'b0, NV + 1));
        check("count_after_reset_on", 32'(active_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
